obstacle_timer: RTL and testbench

OBSTACLE_TIMER -- requirements
Module: obstacle_timer

---
 rtl/obstacle_timer.sv | 166 ++++++++++++++++
 tb/tb_obstacle_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_timer.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_timer
// Description : Sequences one obstacle through warning, live and cooldown
//               phases counted in video frames, then handshakes for the next.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_timer #(
   parameter int NUM_BITS        = 3,
   parameter int WARN_FRAMES     = 30,
   parameter int COOLDOWN_FRAMES = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                play_selected,
   input  logic                frame_tick,
   input  logic                freeze,
   input  logic [NUM_BITS-1:0] obstacle_code,
   input  logic                new_code,
   output logic                done,
   output logic                warn,
   output logic                active,
   output logic [NUM_BITS-1:0] cur_code,
   output logic [7:0]          frames_left
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WARN      = 3'd1,
      S_ACTIVE    = 3'd2,
      S_COOLDOWN  = 3'd3,
      S_WAIT_CODE = 3'd4
   } state_t;

   localparam logic [7:0] c_warn_len = 8'(WARN_FRAMES);
   localparam logic [7:0] c_cool_len = 8'(COOLDOWN_FRAMES);

   state_t              r_state;
   state_t              w_next_state;
   logic                r_play_prev;
   logic [7:0]          r_frames;
   logic [7:0]          w_next_frames;
   logic [NUM_BITS-1:0] r_cur_code;
   logic [NUM_BITS-1:0] w_next_code;
   logic                r_done;
   logic                w_next_done;
   logic                r_warn;
   logic                r_active;
   logic                w_play_rise;
   logic                w_tick;
   logic                w_last_tick;
   logic [2:0]          w_idx;
   logic [7:0]          w_active_len;

   // The live-duration table always looks at three code bits; narrower codes are zero-extended.
   generate
      if (NUM_BITS >= 3) begin : g_idx_full
         assign w_idx = r_cur_code[2:0];
      end else begin : g_idx_narrow
         assign w_idx = {{(3-NUM_BITS){1'b0}}, r_cur_code};
      end
   endgenerate

   always_comb begin
      w_active_len = 8'd120;
      case (w_idx)
         3'd0: w_active_len = 8'd120;
         3'd1: w_active_len = 8'd90;
         3'd2: w_active_len = 8'd150;
         3'd3: w_active_len = 8'd120;
         3'd4: w_active_len = 8'd180;
         3'd5: w_active_len = 8'd90;
         3'd6: w_active_len = 8'd150;
         3'd7: w_active_len = 8'd240;
         default: w_active_len = 8'd120;
      endcase
   end

   assign w_play_rise = play_selected & ~r_play_prev;
   assign w_tick      = frame_tick & ~freeze;
   assign w_last_tick = w_tick && (r_frames == 8'd1);

   always_comb begin
      w_next_state  = r_state;
      w_next_frames = r_frames;
      w_next_code   = r_cur_code;
      w_next_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_play_rise) begin
               w_next_state  = S_WARN;
               w_next_code   = obstacle_code;
               w_next_frames = c_warn_len;
            end
         end
         S_WARN: begin
            if (w_last_tick) begin
               w_next_state  = S_ACTIVE;
               w_next_frames = w_active_len;
            end else if (w_tick) begin
               w_next_frames = r_frames - 8'd1;
            end
         end
         S_ACTIVE: begin
            if (w_last_tick) begin
               w_next_state  = S_COOLDOWN;
               w_next_frames = c_cool_len;
            end else if (w_tick) begin
               w_next_frames = r_frames - 8'd1;
            end
         end
         S_COOLDOWN: begin
            if (w_last_tick) begin
               w_next_state  = S_WAIT_CODE;
               w_next_frames = 8'd0;
               w_next_done   = 1'b1;
            end else if (w_tick) begin
               w_next_frames = r_frames - 8'd1;
            end
         end
         S_WAIT_CODE: begin
            if (new_code) begin
               w_next_state  = S_WARN;
               w_next_code   = obstacle_code;
               w_next_frames = c_warn_len;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      // Leaving play wins over everything, including a done pulse about to fire.
      if (!play_selected) begin
         w_next_state  = S_IDLE;
         w_next_frames = 8'd0;
         w_next_code   = '0;
         w_next_done   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_play_prev <= 1'b0;
         r_frames    <= 8'd0;
         r_cur_code  <= '0;
         r_done      <= 1'b0;
         r_warn      <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_play_prev <= play_selected;
         r_frames    <= w_next_frames;
         r_cur_code  <= w_next_code;
         r_done      <= w_next_done;
         r_warn      <= (w_next_state == S_WARN);
         r_active    <= (w_next_state == S_ACTIVE);
      end
   end

   assign done        = r_done;
   assign warn        = r_warn;
   assign active      = r_active;
   assign cur_code    = r_cur_code;
   assign frames_left = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_timer
// Description : Randomised and directed bench for obstacle_timer against a
//               phase/duration reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       play_selected = 1'b0;
   logic       frame_tick = 1'b0;
   logic       freeze = 1'b0;
   logic [2:0] obstacle_code = 3'd0;
   logic       new_code = 1'b0;
   logic       done;
   logic       warn;
   logic       active;
   logic [2:0] cur_code;
   logic [7:0] frames_left;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: phase 0 idle, 1 warn, 2 live, 3 cooldown, 4 waiting for a code.
   int m_phase = 0;
   int m_left  = 0;
   int m_code  = 0;
   bit m_prev  = 1'b0;
   bit m_done  = 1'b0;

   obstacle_timer #(
      .NUM_BITS(3), .WARN_FRAMES(30), .COOLDOWN_FRAMES(15)
   ) dut (
      .clk(clk), .rst(rst), .play_selected(play_selected),
      .frame_tick(frame_tick), .freeze(freeze), .obstacle_code(obstacle_code),
      .new_code(new_code), .done(done), .warn(warn), .active(active),
      .cur_code(cur_code), .frames_left(frames_left)
   );

   always #5 clk = ~clk;

   function automatic int phase_len(input int phase, input int code);
      int live_tbl [8] = '{120, 90, 150, 120, 180, 90, 150, 240};
      if (phase == 1) return 30;
      if (phase == 2) return live_tbl[code & 7];
      if (phase == 3) return 15;
      return 0;
   endfunction

   task automatic model_step();
      bit tk;
      tk = frame_tick && !freeze;
      m_done = 1'b0;
      if (rst) begin
         m_phase = 0; m_left = 0; m_code = 0; m_prev = 1'b0;
      end else begin
         if (!play_selected) begin
            m_phase = 0; m_left = 0; m_code = 0;
         end else if ((m_phase == 0 && !m_prev) || (m_phase == 4 && new_code)) begin
            m_phase = 1; m_code = int'(obstacle_code); m_left = phase_len(1, m_code);
         end else if (m_phase >= 1 && m_phase <= 3 && tk) begin
            if (m_left > 1) m_left = m_left - 1;
            else begin
               m_phase = m_phase + 1;
               m_left  = phase_len(m_phase, m_code);
               m_done  = (m_phase == 4);
            end
         end
         m_prev = play_selected;
      end
   endtask

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
   endtask

   // One clock: advance the model on the pre-edge inputs, then compare all outputs.
   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      n_checks++;
      if (done === m_done && warn === (m_phase == 1) && active === (m_phase == 2) &&
          cur_code === 3'(m_code) && frames_left === 8'(m_left))
         n_pass++;
      else
         $display("FAIL model t=%0t: got done=%b warn=%b active=%b code=%0d left=%0d, expected done=%b phase=%0d code=%0d left=%0d",
                  $time, done, warn, active, cur_code, frames_left, m_done, m_phase, m_code, m_left);
   endtask

   function automatic bit sel(input int which);
      if (which == 0) return warn;
      if (which == 1) return active;
      return (!warn && !active && frames_left != 8'd0);
   endfunction

   task automatic count_while(input int which, input int start, output int n);
      n = start;
      while (sel(which) && n < 2000) begin
         cyc();
         if (sel(which)) n++;
      end
   endtask

   initial begin
      int n;
      int k;
      cyc(); cyc();
      check("reset_outputs", {done, warn, active, cur_code, frames_left}, 0);

      // Basic timing, code 0, tick every cycle
      rst = 1'b0; play_selected = 1'b1; frame_tick = 1'b1; obstacle_code = 3'd0;
      cyc();
      check("start_warn", warn, 1);
      check("start_frames", frames_left, 30);
      count_while(0, 1, n);  check("warn_len", n, 30);
      check("active_load", frames_left, 120);
      count_while(1, 1, n);  check("active_len_c0", n, 120);
      count_while(2, 1, n);  check("cool_len", n, 15);
      check("done_pulse", done, 1);
      check("done_frames", frames_left, 0);
      cyc();
      check("done_single", done, 0);

      // Handshake with code 7; new_code during ACTIVE is ignored
      new_code = 1'b1; obstacle_code = 3'd7;
      cyc();
      new_code = 1'b0; obstacle_code = 3'd2;
      check("hs_code", cur_code, 7);
      check("hs_warn", warn, 1);
      count_while(0, 1, n);
      new_code = 1'b1; obstacle_code = 3'd3;
      cyc();
      new_code = 1'b0;
      check("ignore_new_code", cur_code, 7);
      count_while(1, 2, n);  check("active_len_c7", n, 240);
      count_while(2, 1, n);

      // Freeze in ACTIVE at frames_left=50
      new_code = 1'b1; obstacle_code = 3'd0;
      cyc();
      new_code = 1'b0;
      n = 0;
      while (!(active && frames_left == 8'd50) && n < 500) begin cyc(); n++; end
      check("reach_50", frames_left, 50);
      freeze = 1'b1;
      repeat (20) cyc();
      check("freeze_hold", frames_left, 50);
      freeze = 1'b0;
      n = 0;
      while (active && n < 500) begin cyc(); n++; end
      check("post_freeze_ticks", n, 50);

      // Abort on the cycle cooldown would expire
      n = 0;
      while (frames_left != 8'd1 && n < 100) begin cyc(); n++; end
      play_selected = 1'b0;
      cyc();
      check("abort_no_done", done, 0);
      check("abort_outputs", {warn, active, cur_code, frames_left}, 0);

      // Mid-run reset with play held high
      play_selected = 1'b1; obstacle_code = 3'd5;
      cyc();
      repeat (5) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("midreset_outputs", {done, warn, active, cur_code, frames_left}, 0);
      cyc();
      check("restart_warn", warn, 1);
      check("restart_frames", frames_left, 30);

      // Sparse ticks, code 1
      rst = 1'b1; cyc(); rst = 1'b0; obstacle_code = 3'd1;
      k = 0; n = 0;
      while (!active && n < 400) begin frame_tick = (k % 4 == 0); k++; cyc(); n++; end
      n = 0;
      while (active && n < 500) begin frame_tick = (k % 4 == 0); k++; cyc(); if (active) n++; end
      n = n + 1;
      check("sparse_active_ok", (n >= 357 && n <= 363) ? 1 : 0, 1);

      // Randomised run
      rst = 1'b1; cyc(); rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         rst           = ($urandom_range(0, 999) == 0);
         play_selected = ($urandom_range(0, 299) != 0);
         frame_tick    = ($urandom_range(0, 3) != 0);
         freeze        = ($urandom_range(0, 7) == 0);
         new_code      = ($urandom_range(0, 9) == 0);
         obstacle_code = 3'($urandom_range(0, 7));
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
